// File: rtl/keccak_ky_pkg.sv
// Shared definitions for the Keccak/Kyber padding and squeeze datapath.
//   WORD_W         : width of the streaming word
//   RATE_SHAKE128  : rate in bits for SHAKE128
//   RATE_SHAKE256  : rate in bits for SHAKE256 / SHA3-256
//   sqz_state_e    : squeeze controller states
//   byte_num       : 3-bit count of valid bytes in a final word, 0 meaning all 8
//                    (same convention as the absorb padder)
package keccak_ky_pkg;

    localparam int WORD_W        = 64;
    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BLK,
        S_EMIT,
        S_REQ
    } sqz_state_e;

    // Expand a byte_num field into a real byte count (0 -> 8).
    function automatic logic [3:0] byte_num_to_count(input logic [2:0] bn);
        return (bn == 3'd0) ? 4'd8 : {1'b0, bn};
    endfunction

endpackage

// File: rtl/keccak_squeeze64_ky_squeeze_shreg.sv
// squeeze_shreg: RATE_W-bit register that loads a full rate block and shifts
// it left by one 64-bit word per request; the top word is always presented.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   load_i  : capture data_i (takes priority over shift_i)
//   shift_i : shift left by one word, zero-filling from the bottom
//   data_i  : rate block, word 0 in the most significant 64 bits
//   top_o   : current top word
module squeeze_shreg
    import keccak_ky_pkg::*;
#(
    parameter int RATE_W = RATE_SHAKE128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [RATE_W-1:0] data_i,
    output logic [WORD_W-1:0] top_o
);

    logic [RATE_W-1:0] sreg_q, sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (load_i) begin
            sreg_d = data_i;
        end else if (shift_i) begin
            sreg_d = {sreg_q[RATE_W-WORD_W-1:0], {WORD_W{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign top_o = sreg_q[RATE_W-1 -: WORD_W];

endmodule

// File: rtl/keccak_squeeze64_ky.sv
// keccak_squeeze64_ky: squeezes out_len bytes from the Keccak rate as a stream
// of 64-bit words (MSB byte first), requesting extra permutations when the
// request spans more than one rate block.
//   clk, reset_n        : clock (rising edge), asynchronous active-low reset
//   start, out_len      : request pulse and byte count (accepted when idle)
//   blk_in, blk_valid   : permuted rate block from the core
//   blk_ready           : block accepted when blk_valid && blk_ready
//   perm_req            : one-cycle pulse asking for another permutation
//   out_data, out_valid : output word and its valid flag
//   out_ready           : consumer handshake
//   out_last            : final word of the request
//   out_byte_num        : valid bytes in the final word (0 = 8), else 0
//   busy, done          : request in progress / one-cycle completion pulse
// Build option: define SQZ_ZERO_TAIL_EN to zero the unused bytes of the final
// word; otherwise raw state bytes are passed through.
module keccak_squeeze64_ky
    import keccak_ky_pkg::*;
#(
    parameter int RATE_W = RATE_SHAKE128,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  out_len,
    input  logic [RATE_W-1:0] blk_in,
    input  logic              blk_valid,
    output logic              blk_ready,
    output logic              perm_req,
    output logic [63:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [2:0]        out_byte_num,
    output logic              busy,
    output logic              done
);

    localparam int NWORDS = RATE_W / WORD_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NWORDS - 1);
    localparam logic [LEN_W-1:0] WORD_BYTES = LEN_W'(WORD_W / 8);

    sqz_state_e        state_q, state_d;
    logic [LEN_W-1:0]  bytes_left_q, bytes_left_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic              done_q, done_d;
    logic              blk_load;
    logic              out_hs;
    logic              last_word;
    logic [WORD_W-1:0] top_word;

    squeeze_shreg #(
        .RATE_W (RATE_W)
    ) u_shreg (
        .clk     (clk),
        .rst_n   (reset_n),
        .load_i  (blk_load),
        .shift_i (out_hs),
        .data_i  (blk_in),
        .top_o   (top_word)
    );

    assign out_valid    = (state_q == S_EMIT);
    assign blk_ready    = (state_q == S_WAIT_BLK);
    assign perm_req     = (state_q == S_REQ);
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign blk_load     = blk_ready && blk_valid;
    assign out_hs       = out_valid && out_ready;
    assign last_word    = out_valid && (bytes_left_q <= WORD_BYTES);
    assign out_last     = last_word;
    assign out_byte_num = last_word ? bytes_left_q[2:0] : 3'd0;

    // out_data is gated by out_valid so it reads 0 whenever no word is offered.
`ifdef SQZ_ZERO_TAIL_EN
    logic [3:0]        keep_bytes;
    logic [WORD_W-1:0] keep_mask;

    always_comb begin
        keep_bytes = byte_num_to_count(out_byte_num);
        keep_mask  = '1;
        if (last_word) begin
            keep_mask = ~({WORD_W{1'b1}} >> {keep_bytes, 3'b000});
        end
    end

    assign out_data = out_valid ? (top_word & keep_mask) : '0;
`else
    assign out_data = out_valid ? top_word : '0;
`endif

    always_comb begin
        state_d      = state_q;
        bytes_left_d = bytes_left_q;
        word_idx_d   = word_idx_q;
        done_d       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    bytes_left_d = out_len;
                    if (out_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_WAIT_BLK;
                    end
                end
            end
            S_WAIT_BLK: begin
                if (blk_valid) begin
                    word_idx_d = '0;
                    state_d    = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    word_idx_d = word_idx_q + IDX_W'(1);
                    if (last_word) begin
                        bytes_left_d = '0;
                        done_d       = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        bytes_left_d = bytes_left_q - WORD_BYTES;
                        if (word_idx_q == LAST_IDX) begin
                            state_d = S_REQ;
                        end
                    end
                end
            end
            S_REQ: begin
                state_d = S_WAIT_BLK;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            bytes_left_q <= '0;
            word_idx_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bytes_left_q <= bytes_left_d;
            word_idx_q   <= word_idx_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_keccak_squeeze64_ky.sv
// Self-checking bench for keccak_squeeze64_ky (RATE_W=1344, LEN_W=16).
// Expected words are taken straight from the byte stream formed by the
// supplied rate blocks; the final-word tail is zeroed when SQZ_ZERO_TAIL_EN is defined.
module tb_keccak_squeeze64_ky;

    localparam int RATE_W = 1344;
    localparam int LEN_W  = 16;
    localparam int NW     = RATE_W / 64;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [LEN_W-1:0]  out_len;
    logic [RATE_W-1:0] blk_in;
    logic              blk_valid;
    logic              blk_ready;
    logic              perm_req;
    logic [63:0]       out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [2:0]        out_byte_num;
    logic              busy;
    logic              done;

    keccak_squeeze64_ky #(
        .RATE_W (RATE_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .out_len      (out_len),
        .blk_in       (blk_in),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .perm_req     (perm_req),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .out_byte_num (out_byte_num),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [RATE_W-1:0] blocks [4];
    logic [63:0] got_d [$];
    logic        got_l [$];
    logic [2:0]  got_b [$];
    int perm_cnt, done_cnt, blk_cnt, hold_err, timing_err, valid_cycles, stall_cycles;
    bit timed_out;

    function automatic void fill_blocks();
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < RATE_W / 32; i++)
                blocks[b][i*32 +: 32] = $urandom();
    endfunction

    // Word k of a len-byte squeeze: the k-th 8-byte group of the block stream.
    function automatic logic [63:0] model_word(input int len, input int k);
        logic [63:0] w;
        w = blocks[k / NW][RATE_W - 1 - 64 * (k % NW) -: 64];
`ifdef SQZ_ZERO_TAIL_EN
        if (k == (len + 7) / 8 - 1 && (len % 8) != 0)
            for (int j = len % 8; j < 8; j++)
                w[63 - 8 * j -: 8] = 8'h00;
`else
        if (len < 0) w = '0;
`endif
        return w;
    endfunction

    // Drives one request with an emulated permutation core and consumer,
    // collecting every accepted word plus protocol observations.
    task automatic run_request(input int len, input int ready_mode, input int stall_after,
                               input int stall_len, input int restart_cyc);
        int cyc, last_hs, last_blk_hs, blk_delay, stall_left, tail;
        bit pending, prev_stall, prev_valid;
        logic [63:0] prev_d;
        logic        prev_l;
        logic [2:0]  prev_b;
        got_d.delete(); got_l.delete(); got_b.delete();
        perm_cnt = 0; done_cnt = 0; blk_cnt = 0; hold_err = 0; timing_err = 0;
        valid_cycles = 0; stall_cycles = 0; timed_out = 1'b0;
        last_hs = -1; last_blk_hs = -100; pending = 1'b1; blk_delay = $urandom_range(0, 2);
        stall_left = stall_len; tail = -1; prev_stall = 1'b0; prev_valid = 1'b0;
        prev_d = '0; prev_l = 1'b0; prev_b = '0;
        @(negedge clk);
        start   = 1'b1;
        out_len = 16'(len);
        for (cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start = (cyc == restart_cyc);
            if (cyc == restart_cyc) out_len = 16'($urandom_range(1, 100));
            if (done) begin
                done_cnt++;
                if (busy || last_hs != cyc - 1) timing_err++;
                if (tail < 0) tail = 3;
            end
            if (perm_req) begin
                perm_cnt++;
                pending   = 1'b1;
                blk_delay = $urandom_range(0, 3);
            end
            if (prev_stall && (!out_valid || out_data !== prev_d ||
                               out_last !== prev_l || out_byte_num !== prev_b))
                hold_err++;
            if (out_valid) valid_cycles++;
            if (out_valid && !prev_valid && last_blk_hs != cyc - 1) timing_err++;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (out_valid && got_d.size() == stall_after && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                        stall_cycles++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                got_b.push_back(out_byte_num);
                last_hs = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_valid = out_valid;
            prev_d = out_data; prev_l = out_last; prev_b = out_byte_num;
            if (pending && blk_delay == 0) begin
                blk_valid = 1'b1;
                blk_in    = blocks[blk_cnt % 4];
            end else begin
                blk_valid = 1'b0;
                if (pending) blk_delay--;
            end
            if (blk_valid && blk_ready) begin
                blk_cnt++;
                pending     = 1'b0;
                last_blk_hs = cyc;
            end
            if (tail == 0) break;
            if (tail > 0) tail--;
        end
        if (tail != 0) timed_out = 1'b1;
        start = 1'b0; out_ready = 1'b0; blk_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; out_len = '0; blk_in = '0; blk_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_last, out_byte_num, out_data, busy, done, perm_req, blk_ready} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b last=%b bn=%0d data=%h busy=%b done=%b perm=%b rdy=%b exp all 0",
                     out_valid, out_last, out_byte_num, out_data, busy, done, perm_req, blk_ready);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_short_word();
        logic [63:0] exp;
`ifdef SQZ_ZERO_TAIL_EN
        exp = 64'h90ABCD0000000000;
`else
        exp = 64'h90ABCDEF11111111;
`endif
        fill_blocks();
        blocks[0][RATE_W-1 -: 64] = 64'h90ABCDEF11111111;
        run_request(3, 0, 0, 0, -1);
        checks++;
        if (timed_out || got_d.size() != 1 || done_cnt != 1 || perm_cnt != 0 || timing_err != 0) begin
            failures++;
            $display("FAIL short_proto got words=%0d done=%0d perm=%0d terr=%0d to=%0d exp 1/1/0/0/0",
                     got_d.size(), done_cnt, perm_cnt, timing_err, timed_out);
        end
        checks++;
        if (got_d[0] !== exp || got_l[0] !== 1'b1 || got_b[0] !== 3'd3) begin
            failures++;
            $display("FAIL short_word got data=%h last=%b bn=%0d exp data=%h last=1 bn=3",
                     got_d[0], got_l[0], got_b[0], exp);
        end
    endtask

    task automatic test_one_block();
        fill_blocks();
        run_request(32, 0, 0, 0, -1);
        checks++;
        if (timed_out || got_d.size() != 4 || done_cnt != 1 || perm_cnt != 0 || blk_cnt != 1 || timing_err != 0) begin
            failures++;
            $display("FAIL one_block_proto got words=%0d done=%0d perm=%0d blks=%0d terr=%0d exp 4/1/0/1/0",
                     got_d.size(), done_cnt, perm_cnt, blk_cnt, timing_err);
        end
        for (int k = 0; k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] !== model_word(32, k) || got_l[k] !== (k == 3) || got_b[k] !== 3'd0) begin
                failures++;
                $display("FAIL one_block_word%0d got %h/%b/%0d exp %h/%b/0",
                         k, got_d[k], got_l[k], got_b[k], model_word(32, k), (k == 3));
            end
        end
    endtask

    task automatic test_multi_block();
        fill_blocks();
        run_request(200, 1, 0, 0, -1);
        checks++;
        if (timed_out || got_d.size() != 25 || done_cnt != 1 || perm_cnt != 1 || blk_cnt != 2 ||
            hold_err != 0 || timing_err != 0) begin
            failures++;
            $display("FAIL multi_proto got words=%0d done=%0d perm=%0d blks=%0d hold=%0d terr=%0d exp 25/1/1/2/0/0",
                     got_d.size(), done_cnt, perm_cnt, blk_cnt, hold_err, timing_err);
        end
        for (int k = 0; k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] !== model_word(200, k) || got_l[k] !== (k == 24) || got_b[k] !== 3'd0) begin
                failures++;
                $display("FAIL multi_word%0d got %h/%b/%0d exp %h/%b/0",
                         k, got_d[k], got_l[k], got_b[k], model_word(200, k), (k == 24));
            end
        end
    endtask

    task automatic test_backpressure();
        fill_blocks();
        // Stall 5 cycles after two words; also re-pulse start with a new length while busy.
        run_request(24, 2, 2, 5, 2);
        checks++;
        if (timed_out || got_d.size() != 3 || done_cnt != 1 || hold_err != 0 || stall_cycles != 5 || timing_err != 0) begin
            failures++;
            $display("FAIL backpressure_proto got words=%0d done=%0d hold=%0d stalls=%0d terr=%0d exp 3/1/0/5/0",
                     got_d.size(), done_cnt, hold_err, stall_cycles, timing_err);
        end
        for (int k = 0; k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] !== model_word(24, k) || got_l[k] !== (k == 2) || got_b[k] !== 3'd0) begin
                failures++;
                $display("FAIL backpressure_word%0d got %h/%b/%0d exp %h/%b/0",
                         k, got_d[k], got_l[k], got_b[k], model_word(24, k), (k == 2));
            end
        end
    endtask

    task automatic test_reset_mid();
        fill_blocks();
        @(negedge clk);
        start = 1'b1; out_len = 16'd24; out_ready = 1'b0; blk_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; blk_valid = 1'b1; blk_in = blocks[0];
        @(negedge clk);
        blk_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== model_word(24, 2) || out_last !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_word2 got valid=%b data=%h last=%b exp 1 %h 1",
                     out_valid, out_data, out_last, model_word(24, 2));
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_last, out_byte_num, out_data, busy, done, perm_req, blk_ready} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got valid=%b last=%b bn=%0d data=%h busy=%b done=%b exp all 0",
                     out_valid, out_last, out_byte_num, out_data, busy, done);
        end
        @(negedge clk);
        reset_n = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        fill_blocks();
        run_request(8, 0, 0, 0, -1);
        checks++;
        if (timed_out || got_d.size() != 1 || done_cnt != 1 || got_d[0] !== model_word(8, 0) ||
            got_l[0] !== 1'b1 || got_b[0] !== 3'd0) begin
            failures++;
            $display("FAIL after_reset_req got words=%0d done=%0d data=%h last=%b bn=%0d exp 1/1 %h 1 0",
                     got_d.size(), done_cnt, got_d[0], got_l[0], got_b[0], model_word(8, 0));
        end
    endtask

    task automatic test_zero_len();
        fill_blocks();
        run_request(0, 0, 0, 0, -1);
        checks++;
        if (timed_out || done_cnt != 1 || timing_err != 0 || valid_cycles != 0 || blk_cnt != 0 || got_d.size() != 0) begin
            failures++;
            $display("FAIL zero_len got done=%0d terr=%0d valid_cycles=%0d blks=%0d words=%0d exp 1/0/0/0/0",
                     done_cnt, timing_err, valid_cycles, blk_cnt, got_d.size());
        end
    endtask

    task automatic test_random();
        int len, n;
        for (int it = 0; it < 6; it++) begin
            fill_blocks();
            len = $urandom_range(1, 400);
            n   = (len + 7) / 8;
            run_request(len, 1, 0, 0, -1);
            checks++;
            if (timed_out || got_d.size() != n || done_cnt != 1 || perm_cnt != (n + NW - 1) / NW - 1 ||
                hold_err != 0 || timing_err != 0) begin
                failures++;
                $display("FAIL random%0d_proto len=%0d got words=%0d done=%0d perm=%0d hold=%0d terr=%0d exp %0d/1/%0d/0/0",
                         it, len, got_d.size(), done_cnt, perm_cnt, hold_err, timing_err, n, (n + NW - 1) / NW - 1);
            end
            for (int k = 0; k < got_d.size(); k++) begin
                checks++;
                if (got_d[k] !== model_word(len, k) || got_l[k] !== (k == n - 1) ||
                    got_b[k] !== ((k == n - 1) ? 3'(len % 8) : 3'd0)) begin
                    failures++;
                    $display("FAIL random%0d_word%0d len=%0d got %h/%b/%0d exp %h/%b/%0d",
                             it, k, len, got_d[k], got_l[k], got_b[k], model_word(len, k),
                             (k == n - 1), (k == n - 1) ? (len % 8) : 0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_word();
        test_one_block();
        test_multi_block();
        test_backpressure();
        test_reset_mid();
        test_zero_len();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
